fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0: first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 4: instruction buffer depth, power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, output, 1: instruction-memory fetch request valid.
REQ-006 SHALL have port req_ready, input, 1: memory accepts the request this cycle.
REQ-007 SHALL have port req_addr, output, 64: fetch address, bits [1:0] always 0.
REQ-008 SHALL have port resp_valid, input, 1: memory returns one instruction word this cycle, in request order.
REQ-009 SHALL have port resp_data, input, 32: returned instruction word.
REQ-010 SHALL have port redirect_valid, input, 1: branch/jump taken; restart fetch.
REQ-011 SHALL have port redirect_pc, input, 64: new fetch address.
REQ-012 SHALL have port stall, input, 1: downstream (IF/ID register) cannot accept an instruction.
REQ-013 SHALL have port instr_valid, output, 1: instr/instr_pc hold a valid fetched instruction.
REQ-014 SHALL have port instr, output, 32: instruction to the IF/ID register.
REQ-015 SHALL have port instr_pc, output, 64: address of instr.

Function
REQ-016 SHALL issue a request when req_valid=1 and req_ready=1, then increment the PC by 4 the following cycle, with a 64-bit modulo wrap (64'hFFFF_FFFF_FFFF_FFFC+4 = 0).
REQ-017 SHALL assert req_valid only when outstanding + buffered < BUF_DEPTH and redirect_valid=0; no request SHALL issue without a free buffer slot.
REQ-018 SHALL hold req_addr stable while req_valid=1 and req_ready=0.
REQ-019 SHALL record {epoch, addr} for each accepted request in an in-flight queue of depth BUF_DEPTH.
REQ-020 On resp_valid, SHALL pop the in-flight queue and push {data, addr} into the instruction buffer only if the recorded epoch equals the current epoch; otherwise the response is discarded.
REQ-021 SHALL ignore resp_valid when no request is outstanding, leaving state unchanged.
REQ-022 SHALL drive instr_valid=1 whenever the buffer is non-empty; instr/instr_pc SHALL show the buffer head.
REQ-023 SHALL make a response visible on instr no earlier than the cycle after resp_valid, because the buffer is registered.
REQ-024 SHALL pop the head when instr_valid=1 and stall=0; contents SHALL be held while stall=1.
REQ-025 SHALL allow a push and a pop in the same cycle, including when the buffer is full.
REQ-026 SHALL sustain one instruction per cycle with 1-cycle memory latency, req_ready=1 and stall=0.
REQ-027 On redirect_valid, SHALL load the PC with {redirect_pc[63:2],2'b00}, toggle the epoch, and empty the buffer at the next edge, with instr_valid=0 the next cycle.
REQ-028 Redirect SHALL take priority over a same-cycle pop, response push, and PC increment; a request accepted in the redirect cycle cannot occur (REQ-017).
REQ-029 SHALL drop in-flight responses older than a redirect, including when back-to-back redirects occur.
REQ-030 SHALL drive instr=32'h0000_0013 (NOP) and instr_pc=0 whenever instr_valid=0.

Reset
REQ-031 While rst=1: PC=RESET_PC, epoch=0, buffer and in-flight queue empty, req_valid=0, instr_valid=0, instr=NOP, instr_pc=0.
REQ-032 Reset asserted mid-operation SHALL abandon all outstanding requests, because memory is reset by the same rst.
REQ-033 The first request SHALL be RESET_PC, in the first cycle after rst deasserts.

Structure
REQ-034 Package pipeline_pkg SHALL hold XLEN=64, ILEN=32, NOP_INSTR=32'h0000_0013, and the fetch-entry struct {instr, pc}.
REQ-035 SHALL instantiate sub-module fetch_fifo, a parameterised synchronous FIFO with flush, twice: once for the in-flight queue and once for the instruction buffer.

Verification
REQ-036 Reset release, RESET_PC=64'h1000, 1-cycle memory, stall=0 -> req_addr 1000,1004,1008 on consecutive cycles; instr_pc 1000,1004,1008 one per cycle.
REQ-037 stall=1 for 5 cycles with BUF_DEPTH=4 -> at most 4 requests outstanding + buffered; head held unchanged; no loss or duplication after release.
REQ-038 Memory latency 3, two requests in flight at 2000/2004, redirect_pc=64'h3002 -> both responses dropped; next instr_pc=3000.
REQ-039 Redirect in the same cycle as a pop and a resp_valid -> buffer empty next cycle, PC=redirect target.
REQ-040 req_ready=0 for 3 cycles -> req_addr stable and PC not advanced.
REQ-041 rst asserted with 3 instructions buffered -> instr_valid=0 next cycle; refetch starts at RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the front end.
// Holds widths, the NOP encoding and the fetch-stage bundles.
package pipeline_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    logic            epoch;
    logic [XLEN-1:0] pc;
  } inflight_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush, used for fetch queues.
// Ports: clk, rst, flush, push/wdata, pop/rdata, empty, count.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still takes a push when a pop frees the slot.
  assign do_push = push && ((count != FULL) || do_pop);
  assign rdata   = mem[rd_ptr];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request issue, in-flight tracking, buffer.
// Ports: clk/rst, req_*/resp_* memory side, redirect_*, stall, instr_*.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter int              BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [ILEN-1:0] resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(BUF_DEPTH);

  logic [XLEN-1:0] pc;
  logic            epoch;
  logic [AW:0]     drop;

  inflight_t    if_in;
  inflight_t    if_out;
  fetch_entry_t buf_in;
  fetch_entry_t buf_out;
  logic         if_empty;
  logic         buf_empty;
  logic [AW:0]  if_cnt;
  logic [AW:0]  buf_cnt;
  logic [AW+1:0] occ;

  logic req_fire;
  logic resp_fire;
  logic live;
  logic buf_pop;

  assign occ       = {1'b0, if_cnt} + {1'b0, buf_cnt};
  assign req_valid = !rst && !redirect_valid && (occ < DEPTH_W);
  assign req_addr  = pc;
  assign req_fire  = req_valid && req_ready;
  assign resp_fire = resp_valid && !if_empty;

  // Responses issued before the latest redirect are counted in drop;
  // the epoch bit alone would alias after two back-to-back redirects.
  assign live = resp_fire && (if_out.epoch == epoch)
             && (drop == '0) && !redirect_valid;

  assign buf_pop = !buf_empty && !stall && !redirect_valid;

  assign if_in  = '{epoch: epoch, pc: pc};
  assign buf_in = '{instr: resp_data, pc: if_out.pc};

  assign instr_valid = !rst && !buf_empty;
  assign instr       = instr_valid ? buf_out.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? buf_out.pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      epoch <= 1'b0;
      drop  <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc & ~64'h3;
      epoch <= ~epoch;
      drop  <= if_cnt - {{AW{1'b0}}, resp_fire};
    end else begin
      if (req_fire) pc <= pc + 64'd4;
      if (resp_fire && drop != '0) drop <= drop - 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(inflight_t)),
    .DEPTH (BUF_DEPTH)
  ) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (if_in),
    .pop   (resp_fire),
    .rdata (if_out),
    .empty (if_empty),
    .count (if_cnt)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (live),
    .wdata (buf_in),
    .pop   (buf_pop),
    .rdata (buf_out),
    .empty (buf_empty),
    .count (buf_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory
// model and an in-order scoreboard of expected {pc, instr}.
module tb_fetch_unit;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint      due;
    logic [63:0] addr;
  } mreq_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  mreq_t  pend[$];
  exp_t   exp_q[$];
  mreq_t  m;
  exp_t   e;
  exp_t   got;
  longint mcyc = 0;
  int     lat = 1;
  logic   spur = 1'b0;
  logic [63:0] head;
  logic [63:0] hold;

  fetch_unit #(
    .RESET_PC  (64'h1000),
    .BUF_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000 ^ {a[47:32], 16'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // Memory model: capture accepts at the edge, answer after lat cycles.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      exp_q.delete();
    end else begin
      if (redirect_valid) exp_q.delete();
      if (req_valid && req_ready) begin
        m.due  = mcyc + longint'(lat);
        m.addr = req_addr;
        pend.push_back(m);
        e.pc  = req_addr;
        e.ins = mdata(req_addr);
        exp_q.push_back(e);
      end
    end
    mcyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= mcyc) begin
      resp_valid = 1'b1;
      resp_data  = mdata(pend[0].addr);
      void'(pend.pop_front());
    end else if (spur) begin
      resp_valid = 1'b1;
      resp_data  = 32'hDEAD_BEEF;
    end else begin
      resp_valid = 1'b0;
      resp_data  = '0;
    end
  end

  // Scoreboard and invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid) begin
        chk("credit", 64'(exp_q.size() < 4), 64'd1);
        chk("align", 64'(req_addr[1:0]), 64'd0);
      end
      if (instr_valid && !stall && !redirect_valid) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("sb_pc", instr_pc, got.pc);
          chk("sb_instr", 64'(instr), 64'(got.ins));
        end
      end
      if (!instr_valid) begin
        chk("nop_instr", 64'(instr), 64'(NOP_INSTR));
        chk("nop_pc", instr_pc, 64'd0);
      end
    end
  end

  task automatic edge_in();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [63:0] pc, input string tag);
    int n = 0;
    while (!instr_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(instr_valid), 64'd1);
    chk(tag, instr_pc, pc);
  endtask

  initial begin
    rst = 1'b1;
    req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'(NOP_INSTR));
    chk("rst_instr_pc", instr_pc, 64'd0);

    // Streaming from RESET_PC with 1-cycle memory.
    edge_in(); rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", 64'(req_valid), 64'd1);
    chk("req0", req_addr, 64'h1000);
    @(negedge clk);
    chk("req1", req_addr, 64'h1004);
    chk("no_instr_yet", 64'(instr_valid), 64'd0);
    @(negedge clk);
    chk("req2", req_addr, 64'h1008);
    chk("ipc0", instr_pc, 64'h1000);
    @(negedge clk);
    chk("ipc1", instr_pc, 64'h1004);
    @(negedge clk);
    chk("ipc2", instr_pc, 64'h1008);

    // Stall for 5 cycles: head held, credit runs out.
    edge_in(); stall = 1'b1;
    @(negedge clk);
    head = instr_pc;
    chk("stall_valid", 64'(instr_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_head", instr_pc, head);
    end
    chk("stall_full", 64'(req_valid), 64'd0);
    edge_in(); stall = 1'b0;
    repeat (6) @(negedge clk);

    // req_ready low: address held, then a spurious response.
    edge_in(); req_ready = 1'b0;
    @(negedge clk);
    hold = req_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ready_hold", req_addr, hold);
    end
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_ignored", 64'(instr_valid), 64'd0);
    chk("spur_pc", req_addr, hold);
    edge_in(); req_ready = 1'b1;
    @(negedge clk);
    chk("ready_resume", req_addr, hold);
    repeat (3) @(negedge clk);

    // Latency 3: two requests in flight, then redirect to 3002.
    edge_in(); lat = 3; redirect_valid = 1'b1; redirect_pc = 64'h2000;
    edge_in(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("r2000", req_addr, 64'h2000);
    edge_in();
    @(negedge clk);
    chk("r2004", req_addr, 64'h2004);
    edge_in(); redirect_valid = 1'b1; redirect_pc = 64'h3002;
    @(negedge clk);
    chk("redir_no_req", 64'(req_valid), 64'd0);
    edge_in(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_empty", 64'(instr_valid), 64'd0);
    chk("redir_pc", req_addr, 64'h3000);
    wait_valid(64'h3000, "redir_first");
    repeat (3) @(negedge clk);

    // Back-to-back redirects with old requests still in flight.
    edge_in(); redirect_valid = 1'b1; redirect_pc = 64'h4000;
    edge_in(); redirect_pc = 64'h5000;
    edge_in(); redirect_valid = 1'b0;
    @(negedge clk);
    wait_valid(64'h5000, "b2b_first");

    // Redirect coinciding with a pop and a response.
    edge_in(); lat = 1;
    repeat (8) @(negedge clk);
    edge_in(); redirect_valid = 1'b1; redirect_pc = 64'h6000;
    @(negedge clk);
    chk("pre39_valid", 64'(instr_valid), 64'd1);
    edge_in(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("r39_empty", 64'(instr_valid), 64'd0);
    chk("r39_pc", req_addr, 64'h6000);
    wait_valid(64'h6000, "r39_first");

    // PC wraps modulo 2^64.
    edge_in(); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9;
    edge_in(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap0", req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    @(negedge clk);
    chk("wrap1", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    chk("wrap2", req_addr, 64'h0);
    repeat (6) @(negedge clk);

    // Reset with three instructions buffered.
    edge_in(); redirect_valid = 1'b1; redirect_pc = 64'h7000; stall = 1'b1;
    edge_in(); redirect_valid = 1'b0;
    edge_in();
    edge_in();
    edge_in(); req_ready = 1'b0;
    edge_in();
    @(negedge clk);
    chk("buf3_head", instr_pc, 64'h7000);
    edge_in(); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 64'(instr_valid), 64'd0);
    edge_in();
    @(negedge clk);
    chk("rst_mid_valid2", 64'(instr_valid), 64'd0);
    chk("rst_mid_req", 64'(req_valid), 64'd0);
    edge_in(); rst = 1'b0; stall = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    chk("refetch_valid", 64'(req_valid), 64'd1);
    chk("refetch_addr", req_addr, 64'h1000);
    wait_valid(64'h1000, "refetch_first");
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
